// File: rtl/adc_spi_engine.sv
// +----------------------------------------------------------------------------+
// | adc_spi_engine: AXI-Stream command word -> SPI mode-0 frame to the ADC     |
// | Optional: ADC_SPI_LOOPBACK_EN feeds sdo back to the receiver. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module adc_spi_engine #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_sdo,
   input  logic        spi_sdi,
   output logic [23:0] rx_data,
   output logic        rx_valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] c_setup   = 8'(CS_SETUP);
   localparam logic [7:0] c_div_m1  = 8'(CLK_DIV - 1);
   localparam logic [7:0] c_hold_m1 = 8'(CS_HOLD - 1);
   localparam logic [7:0] c_gap_m2  = (CS_GAP > 1) ? 8'(CS_GAP - 2) : 8'd0;
   localparam bit         c_has_gap = (CS_GAP > 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  bits_q, bits_d;
   logic [23:0] tx_q, tx_d;
   logic [23:0] rx_shift_q, rx_shift_d;
   logic [23:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        cs_n_q, cs_n_d;
   logic        sck_q, sck_d;
   logic        sdo_q, sdo_d;
   logic        tready_q, tready_d;
   logic        busy_q, busy_d;

   logic [5:0]  cmd_len;
   logic [4:0]  cmd_nbits;
   logic [23:0] cmd_aligned;
   logic        rx_in;

   // Left-align the payload so the first bit on the wire is always tx_q[23].
   assign cmd_len     = {1'b0, s_axis_tdata[28:24]} + 6'd1;
   assign cmd_nbits   = (cmd_len > 6'd24) ? 5'd24 : cmd_len[4:0];
   assign cmd_aligned = s_axis_tdata[23:0] << (5'd24 - cmd_nbits);

`ifdef ADC_SPI_LOOPBACK_EN
   logic unused_inputs;
   assign unused_inputs = ^{s_axis_tdata[31:29], spi_sdi};
   assign rx_in         = sdo_q;
`else
   logic unused_inputs;
   assign unused_inputs = ^s_axis_tdata[31:29];
   assign rx_in         = spi_sdi;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bits_d     = bits_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      sdo_d      = sdo_q;
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid && tready_q) begin
               state_d    = ST_SETUP;
               cnt_d      = c_setup;
               bits_d     = cmd_nbits;
               tx_d       = cmd_aligned;
               sdo_d      = cmd_aligned[23];
               rx_shift_d = 24'd0;
               cs_n_d     = 1'b0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_SHIFT;
               cnt_d   = c_div_m1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (!sck_q) begin
               sck_d      = 1'b1;
               cnt_d      = c_div_m1;
               rx_shift_d = {rx_shift_q[22:0], rx_in};
            end else begin
               sck_d = 1'b0;
               cnt_d = c_div_m1;
               if (bits_q == 5'd1) begin
                  state_d = ST_HOLD;
                  cnt_d   = c_hold_m1;
               end else begin
                  bits_d = bits_q - 5'd1;
                  tx_d   = {tx_q[22:0], 1'b0};
                  sdo_d  = tx_q[22];
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == 8'd0) begin
               cs_n_d     = 1'b1;
               sdo_d      = 1'b0;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               cnt_d      = c_gap_m2;
               state_d    = c_has_gap ? ST_GAP : ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_GAP: begin
            // The IDLE cycle that follows is the last cs_n-high cycle of the gap.
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      tready_d = (state_d == ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         bits_q     <= 5'd0;
         tx_q       <= 24'd0;
         rx_shift_q <= 24'd0;
         rx_data_q  <= 24'd0;
         rx_valid_q <= 1'b0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         sdo_q      <= 1'b0;
         tready_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bits_q     <= bits_d;
         tx_q       <= tx_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         sdo_q      <= sdo_d;
         tready_q   <= tready_d;
         busy_q     <= busy_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign spi_cs_n      = cs_n_q;
   assign spi_sck       = sck_q;
   assign spi_sdo       = sdo_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_engine.sv
// +----------------------------------------------------------------------------+
// | tb_adc_spi_engine: directed vectors plus reset / back-to-back sequences.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_adc_spi_engine;

   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_GAP   = 4;

   typedef struct {
      logic [31:0] tdata;
      logic [23:0] sdi;
      int          nbits;
      logic [23:0] exp_sdo;
      logic [23:0] exp_rx;
      int          exp_low;
   } vec_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_axis_tdata = 32'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_sdo;
   logic        spi_sdi = 1'b0;
   logic [23:0] rx_data;
   logic        rx_valid;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   adc_spi_engine #(
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_GAP  (CS_GAP)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .spi_cs_n     (spi_cs_n),
      .spi_sck      (spi_sck),
      .spi_sdo      (spi_sdo),
      .spi_sdi      (spi_sdi),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (s_axis_tready === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(negedge aclk);
      end
   endtask

   task automatic run_frame(input vec_t v);
      bit          ok;
      bit          done = 1'b0;
      bit          rose_seen = 1'b0;
      logic        valid_at_rise = 1'b0;
      logic [23:0] rx_at_rise = 24'd0;
      logic [23:0] sdo_word = 24'd0;
      logic        prev_sck = 1'b0;
      logic        prev_cs = 1'b1;
      int low_cnt = 0, rises = 0, hi_run = 0, lo_run = 0, width_bad = 0;
      int rxv = 0, sdo_idle_bad = 0, busy_bad = 0, hold_len = -1;
      spi_sdi = v.sdi[v.nbits-1];
      wait_ready(ok);
      chk("ready_before_frame", {31'd0, ok}, 32'd1);
      if (!ok) return;
      s_axis_tdata  = v.tdata;
      s_axis_tvalid = 1'b1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge aclk);
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = 32'hDEAD_BEEF;
         if (!spi_cs_n) low_cnt++;
         if (spi_cs_n && spi_sdo) sdo_idle_bad++;
         if (busy === s_axis_tready) busy_bad++;
         if (rx_valid) rxv++;
         if (spi_sck && !prev_sck) begin
            rises++;
            sdo_word = {sdo_word[22:0], spi_sdo};
            if (rises > 1 && lo_run != CLK_DIV) width_bad++;
            hi_run = 0;
         end
         if (!spi_sck && prev_sck) begin
            if (hi_run != CLK_DIV) width_bad++;
            lo_run = 0;
         end
         if (spi_sck) hi_run++;
         else if (!spi_cs_n) lo_run++;
         if (spi_cs_n && !prev_cs) begin
            rose_seen     = 1'b1;
            hold_len      = lo_run;
            valid_at_rise = rx_valid;
            rx_at_rise    = rx_data;
         end
         if (rose_seen && s_axis_tready) done = 1'b1;
         prev_sck = spi_sck;
         prev_cs  = spi_cs_n;
         if (rises < v.nbits) spi_sdi = v.sdi[v.nbits-1-rises];
      end
      chk("frame_complete", {31'd0, done}, 32'd1);
      chk("sdo_sequence", {8'd0, sdo_word}, {8'd0, v.exp_sdo});
      chk("sck_pulses", rises, v.nbits);
      chk("sck_phase_width_errors", width_bad, 0);
      chk("cs_low_cycles", low_cnt, v.exp_low);
      chk("cs_hold_cycles", hold_len, CS_HOLD);
      chk("rx_valid_at_cs_rise", {31'd0, valid_at_rise}, 32'd1);
      chk("rx_data", {8'd0, rx_at_rise}, {8'd0, v.exp_rx});
      chk("rx_valid_pulses", rxv, 1);
      chk("sdo_high_while_cs_high", sdo_idle_bad, 0);
      chk("busy_vs_tready_errors", busy_bad, 0);
   endtask

   initial begin
      vec_t vecs[5];
      bit   ok;
      vecs[0] = '{32'h0F00_A5A5, 24'h003C3C, 16, 24'h00A5A5, 24'h003C3C, 69};
      vecs[1] = '{32'h1FFF_FFFF, 24'h000000, 24, 24'hFFFFFF, 24'h000000, 101};
      vecs[2] = '{32'h07AB_CD81, 24'h00005A, 8, 24'h000081, 24'h00005A, 37};
      vecs[3] = '{32'hE000_0001, 24'h000001, 1, 24'h000001, 24'h000001, 9};
      vecs[4] = '{32'h1712_3456, 24'h0F0F0F, 24, 24'h123456, 24'h0F0F0F, 101};
`ifdef ADC_SPI_LOOPBACK_EN
      for (int i = 0; i < 5; i++) vecs[i].exp_rx = vecs[i].exp_sdo;
`endif

      // Reset values, then tready one cycle after release.
      repeat (3) @(negedge aclk);
      chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
      chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("rst_sck", {31'd0, spi_sck}, 32'd0);
      chk("rst_sdo", {31'd0, spi_sdo}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_data", {8'd0, rx_data}, 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      chk("tready_after_release", {31'd0, s_axis_tready}, 32'd1);

      for (int i = 0; i < 5; i++) run_frame(vecs[i]);

      // Back-to-back with tvalid held; tdata swapped while busy must be ignored.
      begin
         int   frame = 0, rises1 = 0, rises2 = 0, gap_high = 0;
         logic sdo1 = 1'b0, sdo2 = 1'b1;
         logic prev_cs = 1'b1, prev_sck = 1'b0;
         bit   in_gap = 1'b0, rose2 = 1'b0, done = 1'b0;
         spi_sdi = 1'b0;
         wait_ready(ok);
         chk("b2b_ready", {31'd0, ok}, 32'd1);
         s_axis_tdata  = 32'h0000_0001;
         s_axis_tvalid = 1'b1;
         for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge aclk);
            if (!spi_cs_n && prev_cs) begin
               frame++;
               in_gap = 1'b0;
               if (frame == 1) s_axis_tdata = 32'h1F00_FFFF;
            end
            if (spi_sck && !prev_sck) begin
               if (frame == 1) begin
                  rises1++;
                  sdo1 = spi_sdo;
               end else begin
                  rises2++;
                  sdo2 = spi_sdo;
               end
            end
            if (spi_cs_n && !prev_cs) begin
               if (frame == 1) begin
                  in_gap       = 1'b1;
                  s_axis_tdata = 32'h0000_0000;
               end else begin
                  s_axis_tvalid = 1'b0;
                  rose2         = 1'b1;
               end
            end
            if (in_gap && spi_cs_n) gap_high++;
            if (rose2 && s_axis_tready) done = 1'b1;
            prev_cs  = spi_cs_n;
            prev_sck = spi_sck;
         end
         s_axis_tvalid = 1'b0;
         chk("b2b_complete", {31'd0, done}, 32'd1);
         chk("b2b_frames", frame, 2);
         chk("b2b_f1_pulses", rises1, 1);
         chk("b2b_f1_sdo", {31'd0, sdo1}, 32'd1);
         chk("b2b_f2_pulses", rises2, 1);
         chk("b2b_f2_sdo", {31'd0, sdo2}, 32'd0);
         chk("b2b_cs_high_gap", gap_high, CS_GAP);
      end

      // Reset asserted during the high phase of bit 8 of a 24-bit frame.
      begin
         int   rises = 0, rxv = 0, cs_low = 0;
         logic prev_sck = 1'b0;
         bit   hit = 1'b0;
         spi_sdi = 1'b1;
         wait_ready(ok);
         chk("abort_ready", {31'd0, ok}, 32'd1);
         s_axis_tdata  = 32'h17FF_FFFF;
         s_axis_tvalid = 1'b1;
         for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b0;
            if (rx_valid) rxv++;
            if (spi_sck && !prev_sck) rises++;
            prev_sck = spi_sck;
            if (rises == 8 && spi_sck) begin
               aresetn = 1'b0;
               hit     = 1'b1;
            end
         end
         chk("abort_reached_bit8", {31'd0, hit}, 32'd1);
         @(negedge aclk);
         chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
         chk("abort_sck", {31'd0, spi_sck}, 32'd0);
         chk("abort_busy", {31'd0, busy}, 32'd0);
         chk("abort_tready", {31'd0, s_axis_tready}, 32'd0);
         repeat (2) @(negedge aclk);
         aresetn = 1'b1;
         for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge aclk);
            if (rx_valid) rxv++;
            if (!spi_cs_n) cs_low++;
         end
         chk("abort_no_rx_valid", rxv, 0);
         chk("abort_no_new_frame", cs_low, 0);
         chk("abort_rx_data", {8'd0, rx_data}, 32'd0);
         chk("abort_tready_back", {31'd0, s_axis_tready}, 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adc_spi_engine.md
Name: adc_spi_engine

Overview:
- SPI command engine directly downstream of the ADC config block's AXI-Stream command output (32-bit words).
- Each accepted word becomes one chip-select-framed SPI transaction to the expansion ADC: MSB-first shift out on SDO, simultaneous capture on SDI.
- Read-back word is presented on rx_data with a one-cycle rx_valid pulse, for use as a status input.
- SPI mode 0 (CPOL=0, CPHA=0); one clock domain.

Parameters:
- CLK_DIV, 4: SCK half-period in aclk cycles; legal range 1..255.
- CS_SETUP, 2: aclk cycles from cs_n falling to the first SCK rising edge phase start; legal range 1..255.
- CS_HOLD, 2: aclk cycles from the end of the last SCK high phase to cs_n rising; legal range 1..255.
- CS_GAP, 4: minimum aclk cycles cs_n stays high before the next transaction can be accepted; legal range 1..255.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tdata  in  32  command word: [28:24] nbits-1, [23:0] transmit data right-aligned; [31:29] ignored.
- s_axis_tvalid  in  1  command valid.
- s_axis_tready  out  1  high only in IDLE.
- spi_cs_n  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idle low.
- spi_sdo  out  1  data to ADC.
- spi_sdi  in  1  data from ADC.
- rx_data  out  24  last captured word, right-aligned, zero-extended.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: single clock aclk; reset aresetn is synchronous, active-low. There is no asynchronous reset path.
- Reset values (registered outputs):
  - s_axis_tready=0, spi_cs_n=1, spi_sck=0, spi_sdo=0, rx_data=0, rx_valid=0, busy=0.
  - State is set to IDLE.
- Reset mid-transaction aborts immediately:
  - cs_n goes high and sck goes low on the reset edge.
  - No rx_valid is produced.
- s_axis_tready goes 1 in the first cycle after aresetn is sampled high.
- Bit count: nbits = tdata[28:24]+1. Values 25..32 are clamped to 24.
  - Transmitted bits are tdata[nbits-1] down to tdata[0].
- States and transitions:
  - IDLE: tready=1. On tvalid&tready, latch the shift register and nbits, then go to SETUP. cs_n=0 from the next cycle.
  - SETUP: hold for CS_SETUP cycles with sck=0; sdo = first bit. Then go to SHIFT.
  - SHIFT: each bit is a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
    - sdo changes only at the start of a low phase.
    - sdi is sampled on the aclk edge where sck goes 0→1 and shifted into the receive register LSB-first-in (MSB received first).
    - After the high phase of bit nbits, sck=0 and the state goes to HOLD.
  - HOLD: hold for CS_HOLD cycles, then cs_n=1, go to GAP.
    - rx_data is loaded and rx_valid=1 in the same cycle cs_n rises.
  - GAP: hold for CS_GAP cycles with cs_n=1, then go to IDLE.
- Timing:
  - Handshake to cs_n rising: 1 + CS_SETUP + 2·CLK_DIV·nbits + CS_HOLD cycles.
  - Next tready: CS_GAP cycles after cs_n rises.
- tvalid asserted while not in IDLE is ignored; tdata is not sampled.
- tvalid held across transactions yields back-to-back transactions separated by exactly CS_GAP cs_n-high cycles.
- sdo is 0 whenever cs_n=1.
- busy = (state != IDLE).
- rx_data holds its value until the next completed transaction.

Optional Feature:
- Macro ADC_SPI_LOOPBACK_EN.
- Defined: the internal receive input is sdo, delayed to the sample point, and spi_sdi is ignored. rx_data equals the transmitted data masked to nbits. Used for board bring-up.
- Undefined: the receive input is spi_sdi. No loopback logic is present.

Test Plan:
- All tests use CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=4.
- Reset then release:
  - tready=0, cs_n=1, sck=0 during reset.
  - tready=1 exactly 1 cycle after release.
- Send 0x0F00A5A5 (16 bits), sdi driven with pattern 0x3C3C:
  - sdo sequence is 1010010110100101.
  - 16 sck pulses, each 2 cycles high / 2 cycles low.
  - cs_n is low for 69 cycles.
  - rx_data=0x003C3C with a single rx_valid pulse at cs_n rise.
- Send 0x1FFFFFFF (nbits clamped to 24): exactly 24 sck pulses; sdo all ones.
- tvalid held high with two words 0x00000001 and 0x00000000 (1 bit each):
  - cs_n high for exactly 4 cycles between frames.
  - Second tdata is not sampled before tready.
- Assert aresetn low midway through bit 8 of a 24-bit frame:
  - cs_n=1, sck=0 at the next edge.
  - No rx_valid.
  - rx_data remains 0.
- ADC_SPI_LOOPBACK_EN defined, send 0x17123456: rx_data=0x123456.
